// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Multiplies use a shift-add over a 2*WIDTH accumulator. Divides use a
// restoring algorithm that produces one quotient bit per cycle. Signed
// operations run on magnitudes and fix up the signs in a final cycle.
//
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   start, op          - request an operation (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   operand_a/b        - rs/rt operands, sampled on the accepting edge
//   signal_hi_write    - MTHI: load write_data into hi when idle
//   signal_lo_write    - MTLO: load write_data into lo when idle
//   write_data         - MTHI/MTLO data
//   busy               - operation in flight; start and MTHI/MTLO are ignored
//   done               - one-cycle pulse when hi/lo hold a new result
//   div_by_zero        - pulses with done when a divide had a zero divisor
//   hi, lo             - HI/LO registers
module mips_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             signal_hi_write,
   input  logic             signal_lo_write,
   input  logic [WIDTH-1:0] write_data,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   logic [1:0]         state;
   logic [CW-1:0]      count;
   logic               is_div;
   logic               sign_a;
   logic               sign_b;
   logic               zero_div;
   logic [WIDTH-1:0]   raw_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] acc;

   logic               in_neg_a;
   logic               in_neg_b;
   logic [WIDTH-1:0]   in_mag_a;
   logic [WIDTH-1:0]   in_mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   assign busy = (state != IDLE);

   // Operand magnitudes at the accepting edge; op[0]=1 marks the unsigned forms,
   // so their sign bits are forced to zero and the raw values pass through.
   always_comb begin
      in_neg_a = ~op[0] & operand_a[WIDTH-1];
      in_neg_b = ~op[0] & operand_b[WIDTH-1];
      in_mag_a = in_neg_a ? -operand_a : operand_a;
      in_mag_b = in_neg_b ? -operand_b : operand_b;
   end

   // One iteration of either algorithm. For multiply the multiplier sits in the
   // low half and is shifted out while partial sums enter from the top. For
   // divide the dividend is shifted into the remainder half and quotient bits
   // enter at the bottom; the trial subtraction is one bit wider so its sign
   // bit tells whether the divisor fits.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_b : {WIDTH{1'b0}})};
      div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
      if (is_div) begin
         if (div_trial[WIDTH])
            acc_next = {acc[2*WIDTH-2:0], 1'b0};
         else
            acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_next = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   // Final result with sign correction. A zero divisor overrides everything:
   // hi returns the dividend exactly as it was presented and lo is all ones.
   // The most-negative / -1 case falls out naturally as 0x80..0 with no trap.
   always_comb begin
      res_hi = acc[2*WIDTH-1:WIDTH];
      res_lo = acc[WIDTH-1:0];
      if (zero_div) begin
         res_hi = raw_a;
         res_lo = {WIDTH{1'b1}};
      end else if (is_div) begin
         if (sign_a ^ sign_b)
            res_lo = -acc[WIDTH-1:0];
         if (sign_a)
            res_hi = -acc[2*WIDTH-1:WIDTH];
      end else if (sign_a ^ sign_b) begin
         {res_hi, res_lo} = -acc;
      end
   end

   // Control FSM plus HI/LO. A start in IDLE takes priority over MTHI/MTLO in
   // the same cycle, and HI/LO are left untouched until the FIX cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         count       <= '0;
         is_div      <= 1'b0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         zero_div    <= 1'b0;
         raw_a       <= '0;
         mag_b       <= '0;
         acc         <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  is_div   <= op[1];
                  sign_a   <= in_neg_a;
                  sign_b   <= in_neg_b;
                  zero_div <= op[1] & (operand_b == '0);
                  raw_a    <= operand_a;
                  mag_b    <= in_mag_b;
                  acc      <= {{WIDTH{1'b0}}, in_mag_a};
                  count    <= '0;
                  state    <= CALC;
               end else begin
                  if (signal_hi_write)
                     hi <= write_data;
                  if (signal_lo_write)
                     lo <= write_data;
               end
            end
            CALC: begin
               acc   <= acc_next;
               count <= count + 1'b1;
               if (count == LAST)
                  state <= FIX;
            end
            FIX: begin
               hi          <= res_hi;
               lo          <= res_lo;
               done        <= 1'b1;
               div_by_zero <= zero_div;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit
// Self-checking bench for mips_muldiv_unit. Table-driven operations are issued
// back to back; each accepted start pushes its expected hi/lo/div_by_zero and
// accept cycle onto a scoreboard that a monitor pops whenever done pulses.
// Hand-written sequences cover MTHI/MTLO, busy interactions and reset.
module tb_mips_muldiv_unit;

   localparam int WIDTH = 32;
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;
   localparam int NVEC = 13;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        signal_hi_write;
   logic        signal_lo_write;
   logic [31:0] write_data;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      logic        exp_dbz;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          acc_cyc;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[NVEC];
   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;

   mips_muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .op              (op),
      .operand_a       (operand_a),
      .operand_b       (operand_b),
      .signal_hi_write (signal_hi_write),
      .signal_lo_write (signal_lo_write),
      .write_data      (write_data),
      .busy            (busy),
      .done            (done),
      .div_by_zero     (div_by_zero),
      .hi              (hi),
      .lo              (lo)
   );

   // Free-running clock and a cycle counter used for latency checks.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Result monitor: every done pulse must match the oldest pending expectation,
   // including the accept-to-done distance (accept edge plus WIDTH+1 edges, seen
   // at the following falling edge).
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_done: got done=1, expected done=0");
         end else begin
            e = sb.pop_front();
            checkOutput("hi", hi, e.hi);
            checkOutput("lo", lo, e.lo);
            checkOutput("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
            checkOutput("latency", 32'(cyc - e.acc_cyc), 32'(WIDTH + 2));
         end
      end
   end

   // Waits for idle, presents one start for a single cycle and, when a result
   // is expected, records it together with the cycle of presentation.
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] eh, input logic [31:0] el, input logic ed,
                                input bit expect_done);
      exp_t e;
      int   n = 0;
      while (busy !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL busy_timeout: got busy=%b, expected 0", busy);
      end
      start     = 1'b1;
      op        = o;
      operand_a = a;
      operand_b = b;
      if (expect_done) begin
         e.hi      = eh;
         e.lo      = el;
         e.dbz     = ed;
         e.acc_cyc = cyc;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDrain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
      vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[4]  = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
      vecs[5]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
      vecs[6]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
      vecs[7]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
      vecs[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[9]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vecs[10] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
      vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
      vecs[12] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};

      rst             = 1'b1;
      start           = 1'b0;
      op              = OP_MULT;
      operand_a       = '0;
      operand_b       = '0;
      signal_hi_write = 1'b0;
      signal_lo_write = 1'b0;
      write_data      = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("reset_done", {31'b0, done}, 32'd0);
      checkOutput("reset_dbz", {31'b0, div_by_zero}, 32'd0);
      checkOutput("reset_hi", hi, 32'd0);
      checkOutput("reset_lo", lo, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Back-to-back table operations: each start lands in the previous done cycle.
      for (int i = 0; i < NVEC; i++)
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dbz, 1'b1);
      waitDrain();

      // MTHI and MTLO together while idle.
      signal_hi_write = 1'b1;
      signal_lo_write = 1'b1;
      write_data      = 32'hA5A50001;
      @(negedge clk);
      signal_hi_write = 1'b0;
      signal_lo_write = 1'b0;
      checkOutput("mthi_idle", hi, 32'hA5A50001);
      checkOutput("mtlo_idle", lo, 32'hA5A50001);

      // Start with MTHI in the same cycle: write dropped, hi holds through CALC.
      signal_hi_write = 1'b1;
      write_data      = 32'hDEADBEEF;
      applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
      signal_hi_write = 1'b0;
      checkOutput("start_beats_mthi", hi, 32'hA5A50001);

      // MTHI during busy is ignored.
      repeat (2) @(negedge clk);
      signal_hi_write = 1'b1;
      write_data      = 32'h00001234;
      @(negedge clk);
      signal_hi_write = 1'b0;
      checkOutput("mthi_busy", hi, 32'hA5A50001);

      // A second start while busy must be ignored (result stays 100/7).
      @(negedge clk);
      start     = 1'b1;
      op        = OP_DIVU;
      operand_a = 32'd50;
      operand_b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      waitDrain();

      // MTHI after completion lands.
      signal_hi_write = 1'b1;
      write_data      = 32'h00001234;
      @(negedge clk);
      signal_hi_write = 1'b0;
      checkOutput("mthi_after_done", hi, 32'h00001234);
      checkOutput("lo_kept", lo, 32'd14);

      // Reset mid-operation discards the result; no done may follow.
      applyStimulus(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midreset_busy", {31'b0, busy}, 32'd0);
      checkOutput("midreset_done", {31'b0, done}, 32'd0);
      checkOutput("midreset_hi", hi, 32'd0);
      checkOutput("midreset_lo", lo, 32'd0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      applyStimulus(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b1);
      waitDrain();
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath. It consumes the two register-file read ports (rs, rt) as operands for MULT/MULTU/DIV/DIVU. It computes the result over multiple cycles using shift-add / restoring-divide and holds it in HI/LO. The datapath reads HI/LO for MFHI/MFLO and writes them back into the register file; the controller stalls on `busy`.

## Interface
Parameters:
- WIDTH, 32, operand/result width; counter width is clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when busy=0.
- op  input  2  operation: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
- operand_a  input  WIDTH  rs value (multiplicand / dividend); sampled on the accepting edge.
- operand_b  input  WIDTH  rt value (multiplier / divisor); sampled on the accepting edge.
- signal_hi_write  input  1  MTHI: load write_data into hi.
- signal_lo_write  input  1  MTLO: load write_data into lo.
- write_data  input  WIDTH  data for MTHI/MTLO.
- busy  output  1  operation in progress; start and MTHI/MTLO are ignored.
- done  output  1  one-cycle pulse: hi/lo hold the new result.
- div_by_zero  output  1  registered with done; 1 when a DIV/DIVU had operand_b=0.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).

## Operation
- FSM states: IDLE, CALC, FIX.
  - IDLE: on start=1, latch op, take |a| and |b| (magnitudes for signed ops), record sign bits, clear the accumulator, set count=0, go to CALC.
  - CALC: one iteration per cycle, count increments; after the WIDTH-th iteration (count=WIDTH-1 on that edge), go to FIX.
  - FIX: apply sign correction, write hi/lo, assert done, go to IDLE.
- Multiply: each iteration is a shift-add over the 2*WIDTH accumulator.
  - MULT: product negated when sign_a^sign_b; hi={upper}, lo={lower} of the 2*WIDTH two's-complement product.
- Divide: restoring, one quotient bit per iteration.
  - Signed: truncates toward zero; quotient negated when sign_a^sign_b; remainder takes sign_a.
  - -2^(WIDTH-1) / -1 gives lo=0x80000000, hi=0 (no trap).
- Divide by zero (operand_b=0, DIV or DIVU): full latency still runs; result is hi=operand_a as latched (unsigned raw value), lo=all ones, div_by_zero=1.
- MTHI/MTLO: when busy=0, hi/lo load write_data on the edge. Both may be written in the same cycle.
- Simultaneous events:
  - start and signal_hi/lo_write in the same IDLE cycle: start wins; the write is dropped.
  - start while busy=1: ignored, no queueing.
  - MTHI/MTLO while busy=1: ignored.
- hi/lo keep their previous value throughout CALC; they change only in FIX or on MTHI/MTLO.

## Timing
- Reset (rst=1 at edge): state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, count=0. This holds mid-operation too; the in-flight result is discarded.
- The accepting edge E0 samples start. busy=1 from after E0 until after E(WIDTH+1).
- Edges E1..E(WIDTH) are the CALC iterations. Edge E(WIDTH+1) is FIX: hi/lo update, done=1, busy=0.
- Latency: result is visible WIDTH+1 cycles after the accepting edge (33 for WIDTH=32).
- done and div_by_zero are high for exactly one cycle. div_by_zero returns to 0 with done.
- A new start may be asserted in the cycle where done=1 (busy=0); it is accepted at that edge, giving back-to-back operations.
- hi/lo outputs are register outputs, with no combinational path from inputs.

## Test plan
- Unsigned multiply: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done 33 cycles after accept, hi=0xFFFFFFFE, lo=0x00000001, div_by_zero=0.
- Signed multiply: MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Signed divide:
  - DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: DIVU a=7, b=0 -> hi=0x00000007, lo=0xFFFFFFFF, div_by_zero=1 for one cycle with done.
- Busy interactions:
  - Start DIVU 100/7, pulse start again at cycle 5 with different operands -> second start ignored; result lo=14, hi=2.
  - MTHI 0x1234 during busy is ignored; MTHI 0x1234 after done gives hi=0x1234.
- Reset mid-operation: start MULTU 3*4, assert rst at cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse. A following MULTU 3*4 gives lo=12, hi=0.
